fc_layer_ctrl: RTL and testbench



---
 rtl/fc_layer_ctrl.sv | 130 +++++++++++++
 tb/tb_fc_layer_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_ctrl.sv
// Sequencing controller for the combinational FC multiply/adder-tree datapath: loads the input
// vector, then fetches, computes and streams one neuron result at a time. Build option: FC_RELU_EN.
module fc_layer_ctrl #(
  parameter int INPUT_CHANNEL  = 224,
  parameter int OUTPUT_CHANNEL = 64,
  parameter int BANDWIDTH      = 8,
  parameter int OUT_BANDWIDTH  = 24,
  localparam int AW = $clog2(OUTPUT_CHANNEL),
  localparam int CW = $clog2(INPUT_CHANNEL + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [BANDWIDTH-1:0]     in_data,
  output logic                            w_rd_en,
  output logic        [AW-1:0]            w_rd_addr,
  input  logic signed [BANDWIDTH-1:0]     w_rd_data [INPUT_CHANNEL],
  input  logic signed [BANDWIDTH-1:0]     b_rd_data,
  output logic signed [BANDWIDTH-1:0]     mac_input_data [INPUT_CHANNEL],
  output logic signed [BANDWIDTH-1:0]     mac_weight_data [INPUT_CHANNEL],
  output logic signed [BANDWIDTH-1:0]     mac_bias_data,
  input  logic signed [OUT_BANDWIDTH-1:0] mac_output_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_BANDWIDTH-1:0] out_data,
  output logic        [AW-1:0]            out_index,
  output logic                            out_last
);

  typedef enum logic [2:0] {LOAD, FETCH, LATCH, CAPT, OUT} state_t;

  state_t                     state, state_nxt;
  logic                       armed;
  logic [CW-1:0]              elem_cnt;
  logic [AW-1:0]              neu_cnt;
  logic                       last_elem, last_neu, in_fire, out_fire;
  logic signed [OUT_BANDWIDTH-1:0] capt_data;

  assign last_elem = (elem_cnt == CW'(INPUT_CHANNEL - 1));
  assign last_neu  = (neu_cnt == AW'(OUTPUT_CHANNEL - 1));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign w_rd_addr = neu_cnt;

  // armed keeps in_ready low during reset even though the state already sits in LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    w_rd_en   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = armed;
        if (in_valid && armed && last_elem) state_nxt = FETCH;
      end
      FETCH: begin
        w_rd_en   = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: state_nxt = CAPT;
      CAPT:  state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        out_last  = last_neu;
        if (out_ready) state_nxt = last_neu ? LOAD : FETCH;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      neu_cnt  <= '0;
    end else begin
      if (in_fire) elem_cnt <= elem_cnt + 1'b1;
      if (out_fire) begin
        if (last_neu) begin
          neu_cnt  <= '0;
          elem_cnt <= '0;
        end else begin
          neu_cnt <= neu_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
`ifdef FC_RELU_EN
    capt_data = mac_output_data[OUT_BANDWIDTH-1] ? '0 : mac_output_data;
`else
    capt_data = mac_output_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < INPUT_CHANNEL; i++) begin
        mac_input_data[i]  <= '0;
        mac_weight_data[i] <= '0;
      end
      mac_bias_data <= '0;
      out_data      <= '0;
      out_index     <= '0;
    end else begin
      if (in_fire) mac_input_data[elem_cnt] <= in_data;
      if (state == LATCH) begin
        for (int unsigned i = 0; i < INPUT_CHANNEL; i++) mac_weight_data[i] <= w_rd_data[i];
        mac_bias_data <= b_rd_data;
      end
      if (state == CAPT) begin
        out_data  <= capt_data;
        out_index <= neu_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed/randomized bench for fc_layer_ctrl with a weight-memory responder and an ideal MAC tree;
// results are compared against dot products computed from the bench's own stimulus arrays.
module tb_fc_layer_ctrl;
  localparam int IC  = 224;
  localparam int OC  = 64;
  localparam int BW  = 8;
  localparam int OBW = 24;
  localparam int AW  = 6;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, w_rd_en, out_valid, out_ready, out_last;
  logic signed [BW-1:0]  in_data, b_rd_data, mac_bias_data;
  logic        [AW-1:0]  w_rd_addr, out_index;
  logic signed [BW-1:0]  w_rd_data [IC];
  logic signed [BW-1:0]  mac_input_data [IC];
  logic signed [BW-1:0]  mac_weight_data [IC];
  logic signed [OBW-1:0] mac_output_data, out_data;

  int ncmp = 0;
  int nfail = 0;
  int xv [IC];
  int wm [OC][IC];
  int bm [OC];

  fc_layer_ctrl #(
    .INPUT_CHANNEL (IC),
    .OUTPUT_CHANNEL(OC),
    .BANDWIDTH     (BW),
    .OUT_BANDWIDTH (OBW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .w_rd_en        (w_rd_en),
    .w_rd_addr      (w_rd_addr),
    .w_rd_data      (w_rd_data),
    .b_rd_data      (b_rd_data),
    .mac_input_data (mac_input_data),
    .mac_weight_data(mac_weight_data),
    .mac_bias_data  (mac_bias_data),
    .mac_output_data(mac_output_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (w_rd_en) begin
      for (int i = 0; i < IC; i++) w_rd_data[i] <= BW'(wm[w_rd_addr][i]);
      b_rd_data <= BW'(bm[w_rd_addr]);
    end
  end

  always_comb begin
    int acc;
    acc = int'(mac_bias_data);
    for (int i = 0; i < IC; i++) acc += int'(mac_input_data[i]) * int'(mac_weight_data[i]);
    mac_output_data = OBW'(acc);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: all ones, bias=n; 1: extremes; 2: random; 3: ReLU pattern
  task automatic fill(input int mode);
    for (int i = 0; i < IC; i++)
      xv[i] = (mode == 0 || mode == 3) ? 1 : (mode == 1) ? -128 : int'($urandom_range(0, 255)) - 128;
    for (int n = 0; n < OC; n++) begin
      for (int i = 0; i < IC; i++)
        wm[n][i] = (mode == 0) ? 1 : (mode == 1) ? -128 : (mode == 3) ? -1
                 : int'($urandom_range(0, 255)) - 128;
      bm[n] = (mode == 0) ? n : (mode == 1) ? 127 : (mode == 3) ? 0 : int'($urandom_range(0, 255)) - 128;
    end
  endtask

  function automatic int ref_out(input int n);
    int s;
    s = bm[n];
    for (int i = 0; i < IC; i++) s += xv[i] * wm[n][i];
`ifdef FC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic run_vector(input int hold_n, input int hold_len, input bit gaps);
    int k, cyc, w, mism, bad, stable;
    bit acc, early;
    longint d0, i0, l0;
    k = 0; cyc = 0; early = 0;
    while (k < IC && cyc < 4 * IC + 100) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = BW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = BW'(xv[k]);
      end
      acc = in_valid && in_ready;
      if (w_rd_en) early = 1'b1;
      @(negedge clk);
      cyc++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    in_data  = BW'($urandom);
    check("load_accepts", k, IC);
    check("no_read_during_load", early, 0);
    check("in_ready_low_after_load", in_ready, 0);
    mism = 0;
    for (int i = 0; i < IC; i++) if (mac_input_data[i] !== BW'(xv[i])) mism++;
    check("mac_input_vector", mism, 0);

    for (int n = 0; n < OC; n++) begin
      w = 0;
      while (!w_rd_en && w < 8) begin
        @(negedge clk);
        w++;
      end
      check("fetch_gap", w, 0);
      check("rd_addr", w_rd_addr, n);
      out_ready = (n == hold_n) ? 1'b0 : 1'b1;
      w = 0; bad = 0;
      do begin
        @(negedge clk);
        w++;
        if (w_rd_en) bad = 1;
      end while (!out_valid && w < 8);
      check("valid_latency", w, 3);
      check("single_read", bad, 0);
      check("out_data", out_data, ref_out(n));
      check("out_index", out_index, n);
      check("out_last", out_last, (n == OC - 1) ? 1 : 0);
      if (n == hold_n) begin
        d0 = out_data; i0 = out_index; l0 = out_last; stable = 1;
        repeat (hold_len) begin
          @(negedge clk);
          if (!out_valid || w_rd_en || out_data !== OBW'(d0) || out_index !== AW'(i0) || out_last !== l0[0])
            stable = 0;
        end
        check("backpressure_hold", stable, 1);
        out_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_drop", out_valid, 0);
      if (n == OC - 1) check("in_ready_after_last", in_ready, 1);
    end
    out_ready = 1'(int'($urandom_range(0, 1)));
  endtask

  initial begin
    int k, cyc, nz;
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_w_rd_en", w_rd_en, 0);
    check("rst_w_rd_addr", w_rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_mac_bias", mac_bias_data, 0);
    nz = 0;
    for (int i = 0; i < IC; i++) if (mac_input_data[i] !== '0 || mac_weight_data[i] !== '0) nz++;
    check("rst_mac_arrays", nz, 0);
    rst_n = 1'b1;
    #1 check("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    fill(0); run_vector(-1, 0, 1'b0);
    fill(1); run_vector(-1, 0, 1'b1);
    fill(2); run_vector(5, 10, 1'b1);
    fill(3); run_vector(-1, 0, 1'b0);

    // Abort a partial load, then require a complete fresh vector
    fill(2);
    k = 0; cyc = 0;
    while (k < 100 && cyc < 1000) begin
      in_valid = 1'b1;
      in_data  = BW'($urandom);
      acc = in_ready;
      @(negedge clk);
      cyc++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("partial_accepts", k, 100);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    nz = 0;
    for (int i = 0; i < IC; i++) if (mac_input_data[i] !== '0) nz++;
    check("midrst_vector_cleared", nz, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_release", in_ready, 1);
    run_vector(-1, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
